mem_responder: RTL



---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_byte_lane.sv | 47 ++++
 rtl/mem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder and its byte-lane helper.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   localparam logic [31:0] INIT_WORD0_DEFAULT = 32'h0000_0004;

   typedef struct packed {
      logic        write;
      logic        size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: extracts a sign-extended byte (or passes a word) on loads,
// and merges store data into the stored word on writes.
module mem_byte_lane
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic        size,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0] lane_byte;

   // Little-endian lane select and byte-merge; word accesses bypass the lanes.
   always_comb begin
      lane_byte  = word[7:0];
      store_word = word;
      case (lane)
         2'd0: begin
            lane_byte        = word[7:0];
            store_word[7:0]  = wdata[7:0];
         end
         2'd1: begin
            lane_byte        = word[15:8];
            store_word[15:8] = wdata[7:0];
         end
         2'd2: begin
            lane_byte         = word[23:16];
            store_word[23:16] = wdata[7:0];
         end
         default: begin
            lane_byte         = word[31:24];
            store_word[31:24] = wdata[7:0];
         end
      endcase

      if (size == SIZE_WORD) begin
         load_data  = word;
         store_word = wdata;
      end else begin
         load_data = {{24{lane_byte[7]}}, lane_byte};
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: valid/ready request/response handshake in front of a
// byte-addressed word RAM, with a fixed number of wait states per access.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 32,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] INIT_WORD0  = INIT_WORD0_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  LAT_LOAD   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   mem_state_e    state, state_next;
   logic [3:0]    wait_cnt;
   mem_req_t      req_q, acc_req;
   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   rsp_rdata_q;
   logic          rsp_err_q;

   logic          accept;
   logic          enter_resp;
   logic          in_range;
   logic          misaligned;
   logic          acc_err;
   logic [AW-1:0] word_idx;
   logic [31:0]   cur_word;
   logic [31:0]   load_data;
   logic [31:0]   store_word;

   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Next-state and handshake decode; req_ready depends on the state register alone.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = (LATENCY == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      enter_resp = (state != RESP) && (state_next == RESP);
   end

   // With zero wait states the access edge is also the acceptance edge, so the
   // live request is used directly instead of the not-yet-latched copy.
   always_comb begin
      acc_req = req_q;
      if (state == IDLE) begin
         acc_req = '{write: req_write, size: req_size, addr: req_addr, wdata: req_wdata};
      end
      in_range   = acc_req.addr < BYTE_LIMIT;
      misaligned = (acc_req.size == SIZE_WORD) && (acc_req.addr[1:0] != 2'b00);
      acc_err    = !in_range || misaligned;
      word_idx   = acc_req.addr[AW+1:2];
      cur_word   = in_range ? ram[word_idx] : 32'd0;
   end

   mem_byte_lane u_lane (
      .word       (cur_word),
      .lane       (acc_req.addr[1:0]),
      .size       (acc_req.size),
      .wdata      (acc_req.wdata),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         req_q    <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            req_q    <= acc_req;
            wait_cnt <= LAT_LOAD;
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // RAM and response registers update only on the edge that enters RESP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            ram[i] <= (i == 0) ? INIT_WORD0 : 32'd0;
         end
      end else if (enter_resp) begin
         rsp_err_q   <= acc_err;
         rsp_rdata_q <= (acc_err || acc_req.write) ? 32'd0 : load_data;
         if (!acc_err && acc_req.write) begin
            ram[word_idx] <= store_word;
         end
      end
   end

endmodule
